// File: rtl/axi_lite_sram.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_sram
//  Purpose  : AXI-Lite slave memory model. Serves one outstanding read and
//             one outstanding write at a time from an internal word array,
//             answering each after a programmable latency. Sits behind the
//             LSU master port (or the fetch unit's read-only port).
//  Optional : define YSYX_23060251_SRAM_RAND_DELAY_EN to add 0..7 cycles of
//             pseudo-random latency per transaction and random ready stalls
//             while idle (16-bit Fibonacci LFSR, taps 16,14,13,11).
//  Ports    :
//    clk_i / rst_i                 clock (rising edge), async active-high reset
//    slv_ar_valid_i/addr_i/ready_o read address channel
//    slv_r_valid_o/data_o/resp_o   read data channel, slv_r_ready_i
//    slv_aw_valid_i/addr_i/ready_o write address channel
//    slv_w_valid_i/data_i/strb_i   write data channel, slv_w_ready_o
//    slv_b_valid_o/resp_o          write response channel, slv_b_ready_i
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       READ_LAT  = 1,
  parameter int unsigned       WRITE_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // read address
  input  logic                slv_ar_valid_i,
  input  logic [ADDR_W-1:0]   slv_ar_addr_i,
  output logic                slv_ar_ready_o,
  // read data
  output logic                slv_r_valid_o,
  output logic [DATA_W-1:0]   slv_r_data_o,
  output logic [1:0]          slv_r_resp_o,
  input  logic                slv_r_ready_i,
  // write address
  input  logic                slv_aw_valid_i,
  input  logic [ADDR_W-1:0]   slv_aw_addr_i,
  output logic                slv_aw_ready_o,
  // write data
  input  logic                slv_w_valid_i,
  input  logic [DATA_W-1:0]   slv_w_data_i,
  input  logic [DATA_W/8-1:0] slv_w_strb_i,
  output logic                slv_w_ready_o,
  // write response
  output logic                slv_b_valid_o,
  output logic [1:0]          slv_b_resp_o,
  input  logic                slv_b_ready_i
);

  localparam int unsigned c_strb_w = DATA_W / 8;
  localparam int unsigned c_off_w  = $clog2(c_strb_w);
  localparam int unsigned c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w  = 16;
  localparam logic [c_cnt_w-1:0] c_read_lat_m1  = c_cnt_w'(READ_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_write_lat_m1 = c_cnt_w'(WRITE_LAT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_t;

  typedef enum logic [2:0] {
    R_IDLE  = 3'b001,
    R_DELAY = 3'b010,
    R_RESP  = 3'b100
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE  = 3'b001,
    W_DELAY = 3'b010,
    W_RESP  = 3'b100
  } wr_state_t;

  // --------------------------------------------------------------------------
  // Address decode. Sub-word address bits fall away in the shift.
  // --------------------------------------------------------------------------
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> c_off_w) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [c_idx_w-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = (addr - BASE_ADDR) >> c_off_w;
    return c_idx_w'(off);
  endfunction

  // --------------------------------------------------------------------------
  // Storage (deliberately not reset: contents survive rst_i)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  rd_state_t          r_rd_state, w_rd_state_nxt;
  wr_state_t          r_wr_state, w_wr_state_nxt;

  logic [ADDR_W-1:0]  r_ar_addr;
  logic [c_cnt_w-1:0] r_rd_cnt;
  logic [DATA_W-1:0]  r_rd_data;
  axi_resp_t          r_rd_resp;

  logic [ADDR_W-1:0]  r_aw_addr;
  logic [DATA_W-1:0]  r_w_data;
  logic [c_strb_w-1:0] r_w_strb;
  logic               r_aw_got;
  logic               r_w_got;
  logic [c_cnt_w-1:0] r_wr_cnt;
  axi_resp_t          r_wr_resp;

  // Holds all readies low through reset and for the first cycle after it.
  logic               r_ready_en;

  logic               w_ar_hs, w_aw_hs, w_w_hs;
  logic               w_rd_sample, w_wr_start, w_wr_commit;
  logic               w_rd_ok, w_wr_ok;
  logic [c_idx_w-1:0] w_rd_idx, w_wr_idx;
  logic [c_cnt_w-1:0] w_lat_extra;
  logic               w_stall;

  // --------------------------------------------------------------------------
  // Optional latency randomisation
  // --------------------------------------------------------------------------
`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_lat_extra = c_cnt_w'(r_lfsr[2:0]);
  assign w_stall     = r_lfsr[3];
`else
  assign w_lat_extra = '0;
  assign w_stall     = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Handshakes and decode
  // --------------------------------------------------------------------------
  assign slv_ar_ready_o = r_ready_en && (r_rd_state == R_IDLE) && !w_stall;
  assign slv_aw_ready_o = r_ready_en && (r_wr_state == W_IDLE) && !r_aw_got && !w_stall;
  assign slv_w_ready_o  = r_ready_en && (r_wr_state == W_IDLE) && !r_w_got  && !w_stall;

  assign w_ar_hs = slv_ar_valid_i && slv_ar_ready_o;
  assign w_aw_hs = slv_aw_valid_i && slv_aw_ready_o;
  assign w_w_hs  = slv_w_valid_i  && slv_w_ready_o;

  assign w_rd_sample = (r_rd_state == R_DELAY) && (r_rd_cnt == '0);
  // The final of the two write-side captures may be this very cycle.
  assign w_wr_start  = (r_wr_state == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_wr_commit = (r_wr_state == W_DELAY) && (r_wr_cnt == '0);

  assign w_rd_ok  = addr_ok(r_ar_addr);
  assign w_rd_idx = addr_idx(r_ar_addr);
  assign w_wr_ok  = addr_ok(r_aw_addr);
  assign w_wr_idx = addr_idx(r_aw_addr);

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= R_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      R_IDLE:  if (w_ar_hs)       w_rd_state_nxt = R_DELAY;
      R_DELAY: if (w_rd_sample)   w_rd_state_nxt = R_RESP;
      R_RESP:  if (slv_r_ready_i) w_rd_state_nxt = R_IDLE;
      default:                    w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ar_addr <= '0;
      r_rd_cnt  <= '0;
      r_rd_data <= '0;
      r_rd_resp <= OKAY;
    end else begin
      if (w_ar_hs) begin
        r_ar_addr <= slv_ar_addr_i;
        r_rd_cnt  <= c_read_lat_m1 + w_lat_extra;
      end else if ((r_rd_state == R_DELAY) && (r_rd_cnt != '0)) begin
        r_rd_cnt  <= r_rd_cnt - c_cnt_one;
      end
      // Sampling with a non-blocking read gives read-before-write when a
      // commit to the same word lands on the same edge.
      if (w_rd_sample) begin
        if (w_rd_ok) begin
          r_rd_data <= r_mem[w_rd_idx];
          r_rd_resp <= OKAY;
        end else begin
          r_rd_data <= '0;
          r_rd_resp <= SLVERR;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (w_wr_start)    w_wr_state_nxt = W_DELAY;
      W_DELAY: if (w_wr_commit)   w_wr_state_nxt = W_RESP;
      W_RESP:  if (slv_b_ready_i) w_wr_state_nxt = W_IDLE;
      default:                    w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_wr_cnt  <= '0;
      r_wr_resp <= OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_addr <= slv_aw_addr_i;
        r_aw_got  <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_data  <= slv_w_data_i;
        r_w_strb  <= slv_w_strb_i;
        r_w_got   <= 1'b1;
      end
      // Clearing the capture flags here overrides the sets above.
      if (w_wr_start) begin
        r_aw_got  <= 1'b0;
        r_w_got   <= 1'b0;
        r_wr_cnt  <= c_write_lat_m1 + w_lat_extra;
      end else if ((r_wr_state == W_DELAY) && (r_wr_cnt != '0)) begin
        r_wr_cnt  <= r_wr_cnt - c_cnt_one;
      end
      if (w_wr_commit) begin
        r_wr_resp <= w_wr_ok ? OKAY : SLVERR;
      end
    end
  end

  // Commit only happens from W_DELAY, which reset forces away from, so a
  // write caught by reset is dropped.
  always_ff @(posedge clk_i) begin
    if (w_wr_commit && w_wr_ok) begin
      for (int i = 0; i < c_strb_w; i++) begin
        if (r_w_strb[i]) begin
          r_mem[w_wr_idx][i*8 +: 8] <= r_w_data[i*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign slv_r_valid_o = (r_rd_state == R_RESP);
  assign slv_r_data_o  = r_rd_data;
  assign slv_r_resp_o  = r_rd_resp;
  assign slv_b_valid_o = (r_wr_state == W_RESP);
  assign slv_b_resp_o  = r_wr_resp;

endmodule
`default_nettype wire
